platform_reset_sequencer: RTL and testbench

- Sequences staggered release of downstream platform resets (PCIe PERST, BCM56842, 1G PHY) after PLTRST_N deasserts.
- Also implements the front-panel reset button: debounce, 4 s hold detection, and a fixed-width ResetOut_ox pulse.
- Sits beside the H/W reset generator in ODS_MR, runs on MCLKi (33 MHz), and uses the 32.768 kHz divider output as its time base.

---
 rtl/platform_reset_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_platform_reset_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_reset_sequencer.sv
// Platform reset sequencer: staggered release of PERST / BCM56842 / 1G PHY
// resets after PLTRST_N, plus front-panel button debounce and long-press
// reset pulse generation. Time base is the 32.768 kHz divider output.
module platform_reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PERST_DLY   = 33,
    parameter int unsigned BCM_DLY     = 33,
    parameter int unsigned G1_DLY      = 33,
    parameter int unsigned DEB_TICKS   = 655,
    parameter int unsigned HOLD_TICKS  = 131072,
    parameter int unsigned PULSE_TICKS = 3277,
    parameter int unsigned CNT_W       = 18
) (
    input  logic MCLKi,
    input  logic HARD_nRESETi,
    input  logic CLK32KHz,
    input  logic PLTRST_N,
    input  logic RstBtn_N,
    output logic RstPerst_N,
    output logic RstBcm_N,
    output logic Rst1G_N,
    output logic SeqDone,
    output logic BtnPressed,
    output logic ResetOut_ox
);

    // Zero-length intervals are stretched to one tick so every stage waits at least one tick
    localparam int unsigned PERST_EFF = (PERST_DLY   == 0) ? 1 : PERST_DLY;
    localparam int unsigned BCM_EFF   = (BCM_DLY     == 0) ? 1 : BCM_DLY;
    localparam int unsigned G1_EFF    = (G1_DLY      == 0) ? 1 : G1_DLY;
    localparam int unsigned DEB_EFF   = (DEB_TICKS   == 0) ? 1 : DEB_TICKS;
    localparam int unsigned HOLD_EFF  = (HOLD_TICKS  == 0) ? 1 : HOLD_TICKS;
    localparam int unsigned PULSE_EFF = (PULSE_TICKS == 0) ? 1 : PULSE_TICKS;

    localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_EFF - 1);
    localparam logic [CNT_W-1:0] BCM_LAST   = CNT_W'(BCM_EFF - 1);
    localparam logic [CNT_W-1:0] G1_LAST    = CNT_W'(G1_EFF - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_EFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_PERST,
        W_BCM,
        W_1G,
        RUN
    } seq_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_HOLD,
        B_PULSE,
        B_WAITREL
    } btn_state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] pl_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   clk_prev_q;
    logic                   tick_q;

    logic                   pl_s;
    logic                   btn_raw;

    seq_state_t             seq_state_q, seq_state_d;
    logic [CNT_W-1:0]       seq_cnt_q, seq_cnt_d;
    logic                   perst_d, bcm_d, g1_d, done_d;

    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   btn_pressed_q, btn_pressed_d;

    btn_state_t             btn_state_q, btn_state_d;
    logic [CNT_W-1:0]       btn_cnt_q, btn_cnt_d;
    logic                   rout_d;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pl_s    = pl_sync_q[SYNC_STAGES-1];
    assign btn_raw = ~btn_sync_q[SYNC_STAGES-1];

    // Input synchronizers and one-cycle tick on the synchronized 32 kHz rising edge
    always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
        if (!HARD_nRESETi) begin
            clk_sync_q <= '0;
            pl_sync_q  <= '1;
            btn_sync_q <= '1;
            clk_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            clk_sync_q <= SYNC_STAGES'({clk_sync_q, CLK32KHz});
            pl_sync_q  <= SYNC_STAGES'({pl_sync_q, PLTRST_N});
            btn_sync_q <= SYNC_STAGES'({btn_sync_q, RstBtn_N});
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            tick_q     <= clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        end
    end

    // Sequence FSM next state; a low PLTRST_N overrides any tick or count match
    always_comb begin
        seq_state_d = seq_state_q;
        seq_cnt_d   = seq_cnt_q;
        if (!pl_s) begin
            seq_state_d = IDLE;
            seq_cnt_d   = '0;
        end else begin
            case (seq_state_q)
                IDLE: begin
                    seq_state_d = W_PERST;
                    seq_cnt_d   = '0;
                end
                W_PERST: if (tick_q) begin
                    if (seq_cnt_q == PERST_LAST) begin
                        seq_state_d = W_BCM;
                        seq_cnt_d   = '0;
                    end else begin
                        seq_cnt_d = sat_inc(seq_cnt_q);
                    end
                end
                W_BCM: if (tick_q) begin
                    if (seq_cnt_q == BCM_LAST) begin
                        seq_state_d = W_1G;
                        seq_cnt_d   = '0;
                    end else begin
                        seq_cnt_d = sat_inc(seq_cnt_q);
                    end
                end
                W_1G: if (tick_q) begin
                    if (seq_cnt_q == G1_LAST) begin
                        seq_state_d = RUN;
                        seq_cnt_d   = '0;
                    end else begin
                        seq_cnt_d = sat_inc(seq_cnt_q);
                    end
                end
                RUN:     seq_state_d = RUN;
                default: begin
                    seq_state_d = IDLE;
                    seq_cnt_d   = '0;
                end
            endcase
        end
        // Outputs follow the next state, so release order is fixed by the state order
        perst_d = (seq_state_d == W_BCM) || (seq_state_d == W_1G) || (seq_state_d == RUN);
        bcm_d   = (seq_state_d == W_1G) || (seq_state_d == RUN);
        g1_d    = (seq_state_d == RUN);
        done_d  = (seq_state_d == RUN);
    end

    // Debounce: accept a new button level after DEB ticks of continuous difference
    always_comb begin
        btn_pressed_d = btn_pressed_q;
        deb_cnt_d     = deb_cnt_q;
        if (btn_raw == btn_pressed_q) begin
            deb_cnt_d = '0;
        end else if (tick_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_pressed_d = btn_raw;
                deb_cnt_d     = '0;
            end else begin
                deb_cnt_d = sat_inc(deb_cnt_q);
            end
        end
    end

    // Long-press FSM next state: one fixed-width pulse per press
    always_comb begin
        btn_state_d = btn_state_q;
        btn_cnt_d   = btn_cnt_q;
        case (btn_state_q)
            B_IDLE: if (btn_pressed_q) begin
                btn_state_d = B_HOLD;
                btn_cnt_d   = '0;
            end
            B_HOLD: begin
                if (!btn_pressed_q) begin
                    btn_state_d = B_IDLE;
                    btn_cnt_d   = '0;
                end else if (tick_q) begin
                    if (btn_cnt_q == HOLD_LAST) begin
                        btn_state_d = B_PULSE;
                        btn_cnt_d   = '0;
                    end else begin
                        btn_cnt_d = sat_inc(btn_cnt_q);
                    end
                end
            end
            B_PULSE: if (tick_q) begin
                if (btn_cnt_q == PULSE_LAST) begin
                    btn_state_d = B_WAITREL;
                    btn_cnt_d   = '0;
                end else begin
                    btn_cnt_d = sat_inc(btn_cnt_q);
                end
            end
            B_WAITREL: if (!btn_pressed_q) btn_state_d = B_IDLE;
            default: begin
                btn_state_d = B_IDLE;
                btn_cnt_d   = '0;
            end
        endcase
        rout_d = (btn_state_d != B_PULSE);
    end

    // State, counter and registered output update
    always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
        if (!HARD_nRESETi) begin
            seq_state_q   <= IDLE;
            seq_cnt_q     <= '0;
            RstPerst_N    <= 1'b0;
            RstBcm_N      <= 1'b0;
            Rst1G_N       <= 1'b0;
            SeqDone       <= 1'b0;
            deb_cnt_q     <= '0;
            btn_pressed_q <= 1'b0;
            btn_state_q   <= B_IDLE;
            btn_cnt_q     <= '0;
            ResetOut_ox   <= 1'b1;
        end else begin
            seq_state_q   <= seq_state_d;
            seq_cnt_q     <= seq_cnt_d;
            RstPerst_N    <= perst_d;
            RstBcm_N      <= bcm_d;
            Rst1G_N       <= g1_d;
            SeqDone       <= done_d;
            deb_cnt_q     <= deb_cnt_d;
            btn_pressed_q <= btn_pressed_d;
            btn_state_q   <= btn_state_d;
            btn_cnt_q     <= btn_cnt_d;
            ResetOut_ox   <= rout_d;
        end
    end

    assign BtnPressed = btn_pressed_q;

endmodule

// File: tb/tb_platform_reset_sequencer.sv
// Bench for platform_reset_sequencer: directed tick-level table, hand-written
// corner sequences, and random stimulus against a tick-level reference model.
module tb_platform_reset_sequencer;

    localparam int unsigned PERST_DLY   = 3;
    localparam int unsigned BCM_DLY     = 3;
    localparam int unsigned G1_DLY      = 3;
    localparam int unsigned DEB_TICKS   = 2;
    localparam int unsigned HOLD_TICKS  = 8;
    localparam int unsigned PULSE_TICKS = 4;
    localparam int PERST_AT = PERST_DLY;
    localparam int BCM_AT   = PERST_DLY + BCM_DLY;
    localparam int G1_AT    = PERST_DLY + BCM_DLY + G1_DLY;

    logic MCLKi, HARD_nRESETi, CLK32KHz, PLTRST_N, RstBtn_N;
    logic RstPerst_N, RstBcm_N, Rst1G_N, SeqDone, BtnPressed, ResetOut_ox;

    int checks = 0;
    int errors = 0;
    int ph;

    // model state, advanced once per 32 kHz tick
    int m_rel;
    bit m_pressed;
    int m_diff;
    int m_hold;
    int m_pulse;
    bit m_wait;

    typedef struct packed {
        logic       pl;
        logic       btn_n;
        logic [7:0] ticks;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    platform_reset_sequencer #(
        .SYNC_STAGES(2),
        .PERST_DLY  (PERST_DLY),
        .BCM_DLY    (BCM_DLY),
        .G1_DLY     (G1_DLY),
        .DEB_TICKS  (DEB_TICKS),
        .HOLD_TICKS (HOLD_TICKS),
        .PULSE_TICKS(PULSE_TICKS),
        .CNT_W      (18)
    ) dut (
        .MCLKi       (MCLKi),
        .HARD_nRESETi(HARD_nRESETi),
        .CLK32KHz    (CLK32KHz),
        .PLTRST_N    (PLTRST_N),
        .RstBtn_N    (RstBtn_N),
        .RstPerst_N  (RstPerst_N),
        .RstBcm_N    (RstBcm_N),
        .Rst1G_N     (Rst1G_N),
        .SeqDone     (SeqDone),
        .BtnPressed  (BtnPressed),
        .ResetOut_ox (ResetOut_ox)
    );

    initial begin
        MCLKi = 1'b0;
        forever #5 MCLKi = ~MCLKi;
    end

    // 32 kHz stand-in: 20 MCLKi period, rising when ph wraps to 0
    initial begin
        ph       = 19;
        CLK32KHz = 1'b0;
        forever begin
            @(negedge MCLKi);
            ph       = (ph == 19) ? 0 : ph + 1;
            CLK32KHz = (ph < 10);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic vec_t mk(input logic pl, input logic bn, input int t, input logic [5:0] e);
        vec_t v;
        v.pl    = pl;
        v.btn_n = bn;
        v.ticks = 8'(t);
        v.exp   = e;
        return v;
    endfunction

    function automatic logic [5:0] dut_vec();
        return {RstPerst_N, RstBcm_N, Rst1G_N, SeqDone, BtnPressed, ResetOut_ox};
    endfunction

    function automatic logic [5:0] model_vec();
        return {m_rel >= PERST_AT, m_rel >= BCM_AT, m_rel >= G1_AT, m_rel >= G1_AT,
                m_pressed, m_pulse == 0};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got perst/bcm/1g/done/btn/rout=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rel     = 0;
        m_pressed = 1'b0;
        m_diff    = 0;
        m_hold    = -1;
        m_pulse   = 0;
        m_wait    = 1'b0;
    endtask

    // One tick of the spec rules, using the inputs as currently applied
    task automatic model_tick();
        bit p;
        bit raw;
        p = m_pressed;
        if (PLTRST_N) begin
            if (m_rel < 1000) m_rel++;
        end else begin
            m_rel = 0;
        end
        // level-driven moves that happened since the previous tick
        if (m_wait && !p) m_wait = 1'b0;
        if (m_hold >= 0 && !p) m_hold = -1;
        if (m_hold < 0 && m_pulse == 0 && !m_wait && p) m_hold = 0;
        if (m_hold >= 0) begin
            m_hold++;
            if (m_hold == int'(HOLD_TICKS)) begin
                m_hold  = -1;
                m_pulse = PULSE_TICKS;
            end
        end else if (m_pulse > 0) begin
            m_pulse--;
            if (m_pulse == 0) m_wait = 1'b1;
        end
        raw = ~RstBtn_N;
        if (raw != m_pressed) begin
            m_diff++;
            if (m_diff == int'(DEB_TICKS)) begin
                m_pressed = raw;
                m_diff    = 0;
            end
        end else begin
            m_diff = 0;
        end
    endtask

    task automatic goto_phase(input int p);
        int n;
        n = 0;
        do begin
            @(posedge MCLKi);
            n++;
        end while (ph != p && n < 40);
    endtask

    // Apply inputs between ticks, then advance past the next tick and update the model
    task automatic step(input logic pl, input logic bn);
        goto_phase(15);
        #2;
        PLTRST_N = pl;
        RstBtn_N = bn;
        goto_phase(10);
        #2;
        model_tick();
    endtask

    task automatic step_chk(input string name, input logic pl, input logic bn);
        step(pl, bn);
        check(name, dut_vec(), model_vec());
    endtask

    task automatic hard_reset();
        #3;
        HARD_nRESETi = 1'b0;
        PLTRST_N     = 1'b0;
        RstBtn_N     = 1'b1;
        model_reset();
        repeat (3) @(posedge MCLKi);
        goto_phase(15);
        #3;
        HARD_nRESETi = 1'b1;
    endtask

    initial begin
        int lows;
        int seen;
        logic pl_r, bn_r;

        HARD_nRESETi = 1'b0;
        PLTRST_N     = 1'b0;
        RstBtn_N     = 1'b1;
        model_reset();
        repeat (3) @(posedge MCLKi);
        #2;
        check("reset_state", dut_vec(), 6'b000001);
        goto_phase(15);
        #3;
        HARD_nRESETi = 1'b1;

        // {PLTRST_N, RstBtn_N, ticks, expected perst/bcm/1g/done/btn/rout}
        tbl.push_back(mk(1'b0, 1'b1,  2, 6'b000001));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b000001));
        tbl.push_back(mk(1'b1, 1'b1,  1, 6'b100001));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b100001));
        tbl.push_back(mk(1'b1, 1'b1,  1, 6'b110001));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b110001));
        tbl.push_back(mk(1'b1, 1'b1,  1, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b1,  3, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  7, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111110));
        tbl.push_back(mk(1'b1, 1'b0,  3, 6'b111110));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0, 10, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  2, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  7, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111110));
        tbl.push_back(mk(1'b1, 1'b0,  4, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  5, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b1,  8, 6'b111101));
        tbl.push_back(mk(1'b1, 1'b0,  2, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  7, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b0,  1, 6'b111110));
        tbl.push_back(mk(1'b1, 1'b0,  4, 6'b111111));
        tbl.push_back(mk(1'b1, 1'b1,  2, 6'b111101));

        foreach (tbl[r]) begin
            for (int k = 0; k < int'(tbl[r].ticks); k++) step(tbl[r].pl, tbl[r].btn_n);
            check($sformatf("table_row_%0d", r), dut_vec(), tbl[r].exp);
        end

        // PLTRST_N drop while waiting for the BCM release, then full restart
        step_chk("drop_pre", 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step_chk($sformatf("to_wbcm_%0d", k), 1'b1, 1'b1);
        check("in_w_bcm", dut_vec(), 6'b100001);
        goto_phase(15);
        #2;
        PLTRST_N = 1'b0;
        repeat (3) @(posedge MCLKi);
        #2;
        check("pltrst_drop_latency", dut_vec(), 6'b000001);
        goto_phase(10);
        #2;
        model_tick();
        check("pltrst_drop_tick", dut_vec(), model_vec());
        for (int k = 0; k < G1_AT; k++) step_chk($sformatf("restart_%0d", k), 1'b1, 1'b1);
        check("restart_done", dut_vec(), 6'b111101);

        // Hard reset during an active pulse and during the 1G wait
        for (int k = 0; k < 3; k++) step_chk($sformatf("hr_press_%0d", k), 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step_chk($sformatf("hr_seq_%0d", k), 1'b1, 1'b0);
        check("hr_pulse_and_w1g", dut_vec(), 6'b110010);
        #1;
        HARD_nRESETi = 1'b0;
        #1;
        check("hard_reset_async", dut_vec(), 6'b000001);
        PLTRST_N = 1'b0;
        RstBtn_N = 1'b1;
        model_reset();
        repeat (5) @(posedge MCLKi);
        #2;
        check("hard_reset_held", dut_vec(), 6'b000001);
        goto_phase(15);
        #3;
        HARD_nRESETi = 1'b1;
        for (int k = 0; k < 3; k++) step_chk($sformatf("post_hr_%0d", k), 1'b0, 1'b1);
        check("post_hr_idle", dut_vec(), 6'b000001);

        // Random stimulus against the model
        pl_r = 1'b0;
        bn_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) pl_r = ~pl_r;
            if ($urandom_range(0, 7) == 0) bn_r = ~bn_r;
            step_chk($sformatf("rand_%0d", i), pl_r, bn_r);
        end

        // Exact pulse width in MCLKi cycles, no repeat while held, new pulse on re-press
        hard_reset();
        goto_phase(15);
        #2;
        RstBtn_N = 1'b0;
        seen = 0;
        for (int c = 0; c < 1000 && seen == 0; c++) begin
            @(negedge MCLKi);
            if (!ResetOut_ox) seen = 1;
        end
        check_int("pulse_start_seen", seen, 1);
        lows = seen;
        for (int c = 0; c < 500 && seen == 1; c++) begin
            @(negedge MCLKi);
            if (!ResetOut_ox) lows++;
            else seen = 2;
        end
        check_int("pulse_width_mclk", lows, 80);
        check_int("btn_still_pressed", int'(BtnPressed), 1);
        lows = 0;
        repeat (240) begin
            @(negedge MCLKi);
            if (!ResetOut_ox) lows++;
        end
        check_int("no_second_pulse", lows, 0);
        RstBtn_N = 1'b1;
        repeat (80) @(negedge MCLKi);
        check_int("btn_released", int'(BtnPressed), 0);
        RstBtn_N = 1'b0;
        seen = 0;
        for (int c = 0; c < 1000 && seen == 0; c++) begin
            @(negedge MCLKi);
            if (!ResetOut_ox) seen = 1;
        end
        check_int("repress_pulse_seen", seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
